dr_bank: RTL and testbench



---
 rtl/dr_pkg.sv | 20 ++
 rtl/dr_alu.sv | 53 +++++
 rtl/dr_bank.sv | 97 +++++++++
 tb/tb_dr_bank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dr_pkg.sv
// Shared definitions for the data-register bank: operation codes and flag reset values.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dr_pkg;

    // Operation codes applied to the selected register when the write strobe is high
    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    // Flag values after reset: no carry, and the all-zero register file reads as zero
    localparam logic CF_RST = 1'b0;
    localparam logic ZF_RST = 1'b1;

endpackage

// File: rtl/dr_alu.sv
// Result/flag generator for one register write: load, inc, dec, shifts, rotate, clear.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the result is captured.
module dr_alu
    import dr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic [WIDTH-1:0] dbus_i,
    input  logic             cf_i,
    output logic [WIDTH-1:0] res_o,
    output logic             cf_o,
    output logic             zero_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Compute the new register value and carry; hold/load/clear keep the incoming carry
    always_comb begin
        res_o = opnd_i;
        cf_o  = cf_i;
        case (op_i)
            OP_LOAD: res_o = dbus_i;
            OP_INC: begin
                res_o = opnd_i + ONE;
                cf_o  = (opnd_i == {WIDTH{1'b1}});
            end
            OP_DEC: begin
                res_o = opnd_i - ONE;
                cf_o  = (opnd_i == '0);
            end
            OP_SHL: begin
                res_o = {opnd_i[WIDTH-2:0], 1'b0};
                cf_o  = opnd_i[WIDTH-1];
            end
            OP_SHR: begin
                res_o = {1'b0, opnd_i[WIDTH-1:1]};
                cf_o  = opnd_i[0];
            end
            OP_ROL: begin
                res_o = {opnd_i[WIDTH-2:0], cf_i};
                cf_o  = opnd_i[WIDTH-1];
            end
            OP_CLR:  res_o = '0;
            default: ;
        endcase
    end

    assign zero_o = (res_o == '0);

endmodule

// File: rtl/dr_bank.sv
// Bank of NREG data registers with op-coded writes, three independent read buses, CF/ZF flags.
// Latency: writes visible one cycle after the capturing edge; reads combinational.
// Backpressure: none; a write is taken on every edge with IDR high and a non-hold op.
module dr_bank
    import dr_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREG  = 4,
    localparam int SELW  = (NREG > 2) ? $clog2(NREG) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DBUS,
    input  logic             IDR,
    input  logic [2:0]       OP,
    input  logic [SELW-1:0]  WSEL,
    input  logic [SELW-1:0]  DSEL,
    input  logic [SELW-1:0]  ASEL,
    input  logic [SELW-1:0]  CSEL,
    input  logic             EDR,
    input  logic             EAR,
    input  logic             ECR,
    output logic [WIDTH-1:0] dbus,
    output logic [WIDTH-1:0] abus,
    output logic [WIDTH-1:0] cbus,
    output logic             CF,
    output logic             ZF
);

    // Every select code gets a slot; slots past NREG read zero and reject writes,
    // which keeps the muxes free of range compares for non-power-of-two banks.
    localparam int NSLOT = 1 << SELW;

    logic [WIDTH-1:0] regs_q [NREG];
    logic             cf_q;
    logic             zf_q;

    logic [WIDTH-1:0] slot_val [NSLOT];
    logic [NSLOT-1:0] slot_ok;

    logic             wr_en;
    logic [WIDTH-1:0] res_d;
    logic             cf_d;
    logic             zf_d;

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        if (g < NREG) begin : g_real
            assign slot_val[g] = regs_q[g];
            assign slot_ok[g]  = 1'b1;
        end else begin : g_pad
            assign slot_val[g] = '0;
            assign slot_ok[g]  = 1'b0;
        end
    end

    assign wr_en = IDR && (OP != OP_HOLD) && slot_ok[WSEL];

    dr_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i   (OP),
        .opnd_i (slot_val[WSEL]),
        .dbus_i (DBUS),
        .cf_i   (cf_q),
        .res_o  (res_d),
        .cf_o   (cf_d),
        .zero_o (zf_d)
    );

    // Register array and flags: reset clears everything, a valid write updates one register plus both flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            cf_q <= CF_RST;
            zf_q <= ZF_RST;
        end else if (wr_en) begin
            for (int i = 0; i < NREG; i++) begin
                if (WSEL == SELW'(i)) begin
                    regs_q[i] <= res_d;
                end
            end
            cf_q <= cf_d;
            zf_q <= zf_d;
        end
    end

    // Read buses see current contents (no write bypass); a disabled bus drives zero
    assign dbus = EDR ? '0 : slot_val[DSEL];
    assign abus = EAR ? '0 : slot_val[ASEL];
    assign cbus = ECR ? '0 : slot_val[CSEL];

    assign CF = cf_q;
    assign ZF = zf_q;

endmodule

// File: tb/tb_dr_bank.sv
module tb_dr_bank;
    import dr_pkg::*;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] val;
        logic       cf;
        logic       zf;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic [7:0] DBUS;
    logic       IDR;
    logic [2:0] OP;
    logic [1:0] WSEL, DSEL, ASEL, CSEL;
    logic       EDR, EAR, ECR;
    logic [7:0] dbus, abus, cbus;
    logic       CF, ZF;

    // second bank with a non-power-of-two register count, sharing all inputs
    logic [7:0] d3_dbus, d3_abus, d3_cbus;
    logic       d3_cf, d3_zf;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    dr_bank #(.WIDTH(8), .NREG(4)) dut (
        .CLK(CLK), .RST(RST), .DBUS(DBUS), .IDR(IDR), .OP(OP), .WSEL(WSEL),
        .DSEL(DSEL), .ASEL(ASEL), .CSEL(CSEL), .EDR(EDR), .EAR(EAR), .ECR(ECR),
        .dbus(dbus), .abus(abus), .cbus(cbus), .CF(CF), .ZF(ZF)
    );

    dr_bank #(.WIDTH(8), .NREG(3)) dut3 (
        .CLK(CLK), .RST(RST), .DBUS(DBUS), .IDR(IDR), .OP(OP), .WSEL(WSEL),
        .DSEL(DSEL), .ASEL(ASEL), .CSEL(CSEL), .EDR(EDR), .EAR(EAR), .ECR(ECR),
        .dbus(d3_dbus), .abus(d3_abus), .cbus(d3_cbus), .CF(d3_cf), .ZF(d3_zf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one write cycle, then read the target back on abus and score it against the queued expectation
    task automatic do_write(input logic idr, input logic [2:0] op, input logic [1:0] wsel,
                            input logic [7:0] data, input logic [7:0] ev, input logic ecf,
                            input logic ezf, input string name);
        exp_t e;
        exp_q.push_back('{wsel, ev, ecf, ezf});
        @(negedge CLK);
        IDR = idr; OP = op; WSEL = wsel; DBUS = data;
        @(posedge CLK);
        #1;
        IDR = 1'b0; OP = OP_HOLD;
        EAR = 1'b0; ASEL = wsel;
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (abus !== e.val) begin
                errors++;
                $display("FAIL %s value r%0d: got %h expected %h", name, e.sel, abus, e.val);
            end
            checks++;
            if (CF !== e.cf) begin
                errors++;
                $display("FAIL %s CF: got %b expected %b", name, CF, e.cf);
            end
            checks++;
            if (ZF !== e.zf) begin
                errors++;
                $display("FAIL %s ZF: got %b expected %b", name, ZF, e.zf);
            end
        end
        EAR = 1'b1;
    endtask

    task automatic test_reset();
        // power-on reset values
        checks++;
        if (CF !== 1'b0 || ZF !== 1'b1) begin
            errors++;
            $display("FAIL por_flags: got CF=%b ZF=%b expected CF=0 ZF=1", CF, ZF);
        end
        do_write(1'b1, OP_LOAD, 2'd0, 8'h11, 8'h11, 1'b0, 1'b0, "pre_rst_load");
        do_write(1'b1, OP_LOAD, 2'd2, 8'h80, 8'h80, 1'b0, 1'b0, "pre_rst_load2");
        // mid-cycle async reset while a write is pending
        @(negedge CLK);
        IDR = 1'b1; OP = OP_LOAD; WSEL = 2'd1; DBUS = 8'h5A;
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (CF !== 1'b0 || ZF !== 1'b1) begin
            errors++;
            $display("FAIL rst_flags: got CF=%b ZF=%b expected CF=0 ZF=1", CF, ZF);
        end
        EDR = 1'b0; EAR = 1'b0; ECR = 1'b0;
        DSEL = 2'd0; ASEL = 2'd1; CSEL = 2'd2;
        #1;
        checks++;
        if (dbus !== 8'h00 || abus !== 8'h00 || cbus !== 8'h00) begin
            errors++;
            $display("FAIL rst_regs012: got %h %h %h expected 00 00 00", dbus, abus, cbus);
        end
        @(negedge CLK);
        IDR = 1'b0; OP = OP_HOLD;
        DSEL = 2'd3;
        #1;
        checks++;
        if (dbus !== 8'h00) begin
            errors++;
            $display("FAIL rst_reg3: got %h expected 00", dbus);
        end
        RST = 1'b0;
        EDR = 1'b1; EAR = 1'b1; ECR = 1'b1;
    endtask

    task automatic test_load_read();
        do_write(1'b1, OP_LOAD, 2'd1, 8'h07, 8'h07, 1'b0, 1'b0, "load_r1");
        EAR = 1'b0; ASEL = 2'd1; DSEL = 2'd1; CSEL = 2'd1;
        EDR = 1'b1; ECR = 1'b1;
        #1;
        checks++;
        if (abus !== 8'h07 || dbus !== 8'h00 || cbus !== 8'h00) begin
            errors++;
            $display("FAIL load_oe: got a=%h d=%h c=%h expected a=07 d=00 c=00", abus, dbus, cbus);
        end
        EAR = 1'b1;
    endtask

    task automatic test_wrap();
        do_write(1'b1, OP_LOAD, 2'd2, 8'hFF, 8'hFF, 1'b0, 1'b0, "wrap_load");
        do_write(1'b1, OP_INC,  2'd2, 8'h00, 8'h00, 1'b1, 1'b1, "wrap_inc");
        do_write(1'b1, OP_DEC,  2'd2, 8'h00, 8'hFF, 1'b1, 1'b0, "wrap_dec");
        do_write(1'b1, OP_DEC,  2'd2, 8'h00, 8'hFE, 1'b0, 1'b0, "dec_plain");
        do_write(1'b1, OP_INC,  2'd2, 8'h00, 8'hFF, 1'b0, 1'b0, "inc_plain");
    endtask

    task automatic test_shift_rotate();
        do_write(1'b1, OP_LOAD, 2'd0, 8'hBF, 8'hBF, 1'b0, 1'b0, "sh_load");
        do_write(1'b1, OP_INC,  2'd0, 8'h00, 8'hC0, 1'b0, 1'b0, "sh_inc");
        do_write(1'b1, OP_SHL,  2'd0, 8'h00, 8'h80, 1'b1, 1'b0, "shl");
        do_write(1'b1, OP_ROL,  2'd0, 8'h00, 8'h01, 1'b1, 1'b0, "rol");
        do_write(1'b1, OP_SHR,  2'd0, 8'h00, 8'h00, 1'b1, 1'b1, "shr");
    endtask

    task automatic test_same_cycle();
        do_write(1'b1, OP_LOAD, 2'd3, 8'h05, 8'h05, 1'b1, 1'b0, "sc_load");
        @(negedge CLK);
        ECR = 1'b0; CSEL = 2'd3;
        IDR = 1'b1; OP = OP_LOAD; WSEL = 2'd3; DBUS = 8'h76;
        #1;
        checks++;
        if (cbus !== 8'h05) begin
            errors++;
            $display("FAIL same_cycle_old: got %h expected 05", cbus);
        end
        @(posedge CLK);
        #1;
        IDR = 1'b0; OP = OP_HOLD;
        checks++;
        if (cbus !== 8'h76 || ZF !== 1'b0 || CF !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_new: got %h CF=%b ZF=%b expected 76 CF=1 ZF=0", cbus, CF, ZF);
        end
        ECR = 1'b1;
    endtask

    task automatic test_hold_strobe();
        do_write(1'b1, OP_LOAD, 2'd0, 8'hC0, 8'hC0, 1'b1, 1'b0, "hs_load_r0");
        do_write(1'b1, OP_LOAD, 2'd1, 8'h05, 8'h05, 1'b1, 1'b0, "hs_load_r1");
        do_write(1'b0, OP_CLR,  2'd3, 8'h00, 8'h76, 1'b1, 1'b0, "strobe_low");
        do_write(1'b1, OP_HOLD, 2'd3, 8'h00, 8'h76, 1'b1, 1'b0, "op_hold");
        EDR = 1'b0; EAR = 1'b0; ECR = 1'b0;
        DSEL = 2'd1; ASEL = 2'd3; CSEL = 2'd0;
        #1;
        checks++;
        if (dbus !== 8'h05 || abus !== 8'h76 || cbus !== 8'hC0) begin
            errors++;
            $display("FAIL three_bus: got %h/%h/%h expected 05/76/C0", dbus, abus, cbus);
        end
        EDR = 1'b1; EAR = 1'b1; ECR = 1'b1;
        do_write(1'b1, OP_CLR, 2'd3, 8'hAA, 8'h00, 1'b1, 1'b1, "clear");
    endtask

    task automatic test_oob();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        // 4-reg bank accepts r3; 3-reg bank must ignore it and keep reset flags
        do_write(1'b1, OP_LOAD, 2'd3, 8'h55, 8'h55, 1'b0, 1'b0, "oob_main");
        EAR = 1'b0; ASEL = 2'd3;
        #1;
        checks++;
        if (d3_abus !== 8'h00) begin
            errors++;
            $display("FAIL oob_read: got %h expected 00", d3_abus);
        end
        checks++;
        if (d3_cf !== 1'b0 || d3_zf !== 1'b1) begin
            errors++;
            $display("FAIL oob_flags: got CF=%b ZF=%b expected CF=0 ZF=1", d3_cf, d3_zf);
        end
        EAR = 1'b1;
    endtask

    initial begin
        RST = 1'b1;
        DBUS = 8'h00; IDR = 1'b0; OP = OP_HOLD;
        WSEL = 2'd0; DSEL = 2'd0; ASEL = 2'd0; CSEL = 2'd0;
        EDR = 1'b1; EAR = 1'b1; ECR = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        test_reset();
        test_load_read();
        test_wrap();
        test_shift_rotate();
        test_same_cycle();
        test_hold_strobe();
        test_oob();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
